// File: rtl/uart_rx_capture_if.sv
// Byte stream leaving the UART receiver FIFO: head byte, valid, and consumer ready.
interface uart_rx_capture_if;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;

  modport master (output data_o, output valid_o, input ready_i);
  modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, and a byte FIFO
// drained through a valid/ready stream.
module uart_rx_capture #(
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_en_i,
  input  logic [DIV_WIDTH-1:0]          baud_div_i,
  input  logic                          rx_i,
  uart_rx_capture_if.master             bus,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o,
  output logic                          busy_o,
  output logic                          frame_err_o,
  output logic                          overrun_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
  typedef logic [AW:0] ptr_t;

  logic                 r_rx_meta, r_rx_s;
  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_cnt, r_div;
  logic [2:0]           r_bitidx;
  logic [7:0]           r_shift;
  logic                 r_busy, r_frame_err, r_overrun;
  logic [7:0]           r_mem [FIFO_DEPTH];
  ptr_t                 r_wr_ptr, r_rd_ptr;

  logic [DIV_WIDTH-1:0] w_half, w_last;
  logic                 w_empty, w_full, w_push, w_pop, w_accept;

  assign w_half = r_div >> 1;
  assign w_last = r_div - DIV_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Half-period START phase puts every following cnt==div-1 sample at mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_div       <= '0;
      r_bitidx    <= '0;
      r_shift     <= '0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (!rx_en_i) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_state <= S_START;
              r_div   <= baud_div_i;
              r_busy  <= 1'b1;
            end
          end
          S_START: begin
            if (r_cnt == w_half) begin
              r_cnt <= '0;
              if (r_rx_s) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state  <= S_DATA;
                r_bitidx <= '0;
              end
            end else begin
              r_cnt <= r_cnt + DIV_WIDTH'(1);
            end
          end
          S_DATA: begin
            if (r_cnt == w_last) begin
              r_cnt    <= '0;
              r_shift  <= {r_rx_s, r_shift[7:1]};
              r_bitidx <= r_bitidx + 3'd1;
              if (r_bitidx == 3'd7) r_state <= S_STOP;
            end else begin
              r_cnt <= r_cnt + DIV_WIDTH'(1);
            end
          end
          S_STOP: begin
            if (r_cnt == w_last) begin
              r_cnt <= '0;
              if (r_rx_s) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state     <= S_BREAK;
                r_frame_err <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + DIV_WIDTH'(1);
            end
          end
          S_BREAK: begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign w_push   = rx_en_i && (r_state == S_STOP) && (r_cnt == w_last) && r_rx_s;
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop    = !w_empty && bus.ready_i;
  // When full, the write slot is the head being popped this cycle, so both can proceed.
  assign w_accept = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_overrun <= w_push && w_full && !w_pop;
      if (w_accept) begin
        r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
        r_wr_ptr                <= r_wr_ptr + ptr_t'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + ptr_t'(1);
    end
  end

  assign bus.data_o  = r_mem[r_rd_ptr[AW-1:0]];
  assign bus.valid_o = !w_empty;
  assign fill_o      = r_wr_ptr - r_rd_ptr;
  assign busy_o      = r_busy;
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;

endmodule
